// File: rtl/exe_muldiv.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// One op at a time: shift-add multiply or restoring divide, one bit per cycle.
module exe_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        muldiv_flush,
  input  logic        muldiv_req,
  input  logic [2:0]  muldiv_funct3,
  input  logic        muldiv_word,
  input  logic [63:0] muldiv_rs1,
  input  logic [63:0] muldiv_rs2,
  input  logic        muldiv_ack,
  output logic        muldiv_ready,
  output logic [63:0] muldiv_result
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned WLEN  = 32;
  localparam int unsigned PLEN  = 2 * XLEN;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             in_div, in_sa, in_sb;
  logic [XLEN-1:0]  a_ext, b_ext, mag_a, mag_b, a_min;
  logic             b_zero, ovf, in_special;
  logic [XLEN-1:0]  special_res;

  logic [2:0]       op_f3;
  logic             op_word, op_neg_a, op_neg_b;
  logic [CNT_W-1:0] cnt;
  logic [PLEN-1:0]  acc, mcand;
  logic [XLEN-1:0]  mplier;

  logic [PLEN-1:0]  acc_it, mcand_it, prod_fix;
  logic [XLEN-1:0]  mplier_it, quo_fix, rem_fix, fin_res;
  logic [XLEN:0]    shifted, trial;
  logic             ge;

  logic             load, step, spec_ld, fin_ld;

  // Decode the incoming request: operand extension, magnitudes, special cases
  always_comb begin
    in_div = muldiv_funct3[2];
    in_sa  = (muldiv_funct3 != 3'd3) && (muldiv_funct3 != 3'd5) && (muldiv_funct3 != 3'd7);
    in_sb  = in_sa && (muldiv_funct3 != 3'd2);
    a_ext  = muldiv_rs1;
    b_ext  = muldiv_rs2;
    a_min  = {1'b1, {(XLEN-1){1'b0}}};
    if (muldiv_word) begin
      a_ext = {{WLEN{in_sa & muldiv_rs1[WLEN-1]}}, muldiv_rs1[WLEN-1:0]};
      b_ext = {{WLEN{in_sb & muldiv_rs2[WLEN-1]}}, muldiv_rs2[WLEN-1:0]};
      a_min = {{(WLEN+1){1'b1}}, {(WLEN-1){1'b0}}};
    end
    mag_a = (in_sa && a_ext[XLEN-1]) ? (~a_ext + XLEN'(1)) : a_ext;
    mag_b = (in_sb && b_ext[XLEN-1]) ? (~b_ext + XLEN'(1)) : b_ext;
    b_zero     = (b_ext == '0);
    ovf        = in_div && in_sb && (a_ext == a_min) && (b_ext == '1);
    in_special = in_div && (b_zero || ovf);
    if (b_zero) special_res = muldiv_funct3[1] ? a_ext : '1;
    else        special_res = muldiv_funct3[1] ? '0 : a_ext;
    if (muldiv_word) special_res = {{WLEN{special_res[WLEN-1]}}, special_res[WLEN-1:0]};
  end

  // One iteration of the datapath plus the sign fix-up of its outcome
  always_comb begin
    acc_it    = acc;
    mcand_it  = mcand;
    mplier_it = mplier;
    shifted   = {acc[XLEN-1:0], mplier[XLEN-1]};
    trial     = shifted - {1'b0, mcand[XLEN-1:0]};
    ge        = ~trial[XLEN];
    if (op_f3[2]) begin
      acc_it    = {acc[PLEN-1:XLEN], ge ? trial[XLEN-1:0] : shifted[XLEN-1:0]};
      mplier_it = {mplier[XLEN-2:0], ge};
    end else begin
      acc_it    = mplier[0] ? (acc + mcand) : acc;
      mcand_it  = mcand << 1;
      mplier_it = mplier >> 1;
    end
    prod_fix = (op_neg_a ^ op_neg_b) ? (~acc_it + PLEN'(1)) : acc_it;
    quo_fix  = (op_neg_a ^ op_neg_b) ? (~mplier_it + XLEN'(1)) : mplier_it;
    rem_fix  = op_neg_a ? (~acc_it[XLEN-1:0] + XLEN'(1)) : acc_it[XLEN-1:0];
    if (op_f3[2])              fin_res = op_f3[1] ? rem_fix : quo_fix;
    else if (op_f3[1:0] == '0) fin_res = prod_fix[XLEN-1:0];
    else                       fin_res = prod_fix[PLEN-1:XLEN];
    if (op_word) fin_res = {{WLEN{fin_res[WLEN-1]}}, fin_res[WLEN-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state; flush overrides both a new request and the ack
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    spec_ld   = 1'b0;
    fin_ld    = 1'b0;
    if (muldiv_flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (muldiv_req) begin
            if (in_special) begin
              spec_ld   = 1'b1;
              state_nxt = S_DONE;
            end else begin
              load      = 1'b1;
              state_nxt = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          step = 1'b1;
          if (cnt == CNT_W'(1)) begin
            fin_ld    = 1'b1;
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (muldiv_ack) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign muldiv_ready = ~muldiv_req | (state == S_DONE);

  // Operand/iteration registers and the registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      op_f3         <= '0;
      op_word       <= 1'b0;
      op_neg_a      <= 1'b0;
      op_neg_b      <= 1'b0;
      cnt           <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
      muldiv_result <= '0;
    end else begin
      if (load) begin
        op_f3    <= muldiv_funct3;
        op_word  <= muldiv_word;
        op_neg_a <= in_sa & a_ext[XLEN-1];
        op_neg_b <= in_sb & b_ext[XLEN-1];
        cnt      <= muldiv_word ? CNT_W'(WLEN) : CNT_W'(XLEN);
        acc      <= '0;
        mcand    <= {{XLEN{1'b0}}, in_div ? mag_b : mag_a};
        if (!in_div)          mplier <= mag_b;
        else if (muldiv_word) mplier <= {mag_a[WLEN-1:0], {WLEN{1'b0}}};
        else                  mplier <= mag_a;
      end
      if (step) begin
        cnt    <= cnt - CNT_W'(1);
        acc    <= acc_it;
        mcand  <= mcand_it;
        mplier <= mplier_it;
      end
      if (spec_ld) muldiv_result <= special_res;
      if (fin_ld)  muldiv_result <= fin_res;
    end
  end

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed cases and randomized ops
// against an arithmetic reference model.
module tb_exe_muldiv;

  logic        clk;
  logic        rst;
  logic        muldiv_flush;
  logic        muldiv_req;
  logic [2:0]  muldiv_funct3;
  logic        muldiv_word;
  logic [63:0] muldiv_rs1;
  logic [63:0] muldiv_rs2;
  logic        muldiv_ack;
  logic        muldiv_ready;
  logic [63:0] muldiv_result;

  int errors = 0;
  int checks = 0;

  localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN  = 64'h8000_0000_0000_0000;

  exe_muldiv dut (
    .clk           (clk),
    .rst           (rst),
    .muldiv_flush  (muldiv_flush),
    .muldiv_req    (muldiv_req),
    .muldiv_funct3 (muldiv_funct3),
    .muldiv_word   (muldiv_word),
    .muldiv_rs1    (muldiv_rs1),
    .muldiv_rs2    (muldiv_rs2),
    .muldiv_ack    (muldiv_ack),
    .muldiv_ready  (muldiv_ready),
    .muldiv_result (muldiv_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics written with native arithmetic
  function automatic logic [63:0] model(input logic [2:0] f3, input bit w,
                                        input logic [63:0] a, input logic [63:0] b);
    int          s1w, s2w;
    logic [31:0] u1w, u2w, r32;
    longint      s1, s2;
    logic [127:0] p;
    logic [63:0] r;
    r = '0;
    if (w) begin
      u1w = a[31:0];
      u2w = b[31:0];
      s1w = u1w;
      s2w = u2w;
      case (f3)
        3'd0: r32 = u1w * u2w;
        3'd4: if (u2w == 0) r32 = '1;
              else if (u1w == 32'h8000_0000 && u2w == 32'hFFFF_FFFF) r32 = u1w;
              else r32 = 32'(s1w / s2w);
        3'd5: r32 = (u2w == 0) ? 32'hFFFF_FFFF : u1w / u2w;
        3'd6: if (u2w == 0) r32 = u1w;
              else if (u1w == 32'h8000_0000 && u2w == 32'hFFFF_FFFF) r32 = '0;
              else r32 = 32'(s1w % s2w);
        3'd7: r32 = (u2w == 0) ? u1w : u1w % u2w;
        default: r32 = '0;
      endcase
      return {{32{r32[31]}}, r32};
    end
    s1 = a;
    s2 = b;
    case (f3)
      3'd0: r = a * b;
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
      3'd4: if (b == 0) r = ALL1;
            else if (a == SMIN && b == ALL1) r = a;
            else r = 64'(s1 / s2);
      3'd5: r = (b == 0) ? ALL1 : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == SMIN && b == ALL1) r = '0;
            else r = 64'(s1 % s2);
      3'd7: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int lat(input logic [2:0] f3, input bit w,
                             input logic [63:0] a, input logic [63:0] b);
    bit bz, ov;
    if (f3[2]) begin
      bz = w ? (b[31:0] == 32'd0) : (b == 64'd0);
      ov = (f3 == 3'd4 || f3 == 3'd6) &&
           (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
              : (a == SMIN && b == ALL1));
      if (bz || ov) return 1;
    end
    return w ? 33 : 65;
  endfunction

  // Called at a negedge; that cycle is cycle 0. Returns at the negedge after the ack.
  task automatic do_op(input string tag, input logic [2:0] f3, input bit w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat, input int hold);
    int cyc;
    muldiv_req    = 1'b1;
    muldiv_funct3 = f3;
    muldiv_word   = w;
    muldiv_rs1    = a;
    muldiv_rs2    = b;
    muldiv_ack    = 1'b0;
    #1;
    chk({tag, "_ready_c0"}, 64'(muldiv_ready), 64'd0);
    cyc = 0;
    while (muldiv_ready !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_result"}, muldiv_result, exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      #1;
      chk({tag, "_hold_ready"}, 64'(muldiv_ready), 64'd1);
      chk({tag, "_hold_result"}, muldiv_result, exp);
    end
    muldiv_ack = 1'b1;
    @(negedge clk);
    muldiv_ack = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    bit          w;
    logic [63:0] a, b;
    int          sel;

    rst           = 1'b1;
    muldiv_flush  = 1'b0;
    muldiv_req    = 1'b0;
    muldiv_funct3 = '0;
    muldiv_word   = 1'b0;
    muldiv_rs1    = '0;
    muldiv_rs2    = '0;
    muldiv_ack    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_result", muldiv_result, 64'd0);
    chk("reset_ready_noreq", 64'(muldiv_ready), 64'd1);
    muldiv_req = 1'b1;
    #1;
    chk("reset_ready_req", 64'(muldiv_ready), 64'd0);
    muldiv_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    do_op("mul_7_m3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
          64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    do_op("mulhu_max", 3'd3, 1'b0, ALL1, ALL1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 5);
    do_op("mulh_m1_1", 3'd1, 1'b0, ALL1, 64'd1, ALL1, 65, 0);
    do_op("div_ovf", 3'd4, 1'b0, SMIN, ALL1, SMIN, 1, 0);
    do_op("rem_ovf", 3'd6, 1'b0, SMIN, ALL1, 64'd0, 1, 0);
    do_op("divu_by0", 3'd5, 1'b0, 64'd5, 64'd0, ALL1, 1, 0);
    do_op("remu_by0", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
    do_op("remw_m7_2", 3'd6, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, ALL1, 33, 0);
    muldiv_req = 1'b0;
    @(negedge clk);

    // Flush a DIV at cycle 20, then start a DIVU in the following cycle
    muldiv_req    = 1'b1;
    muldiv_funct3 = 3'd4;
    muldiv_word   = 1'b0;
    muldiv_rs1    = 64'h1234_5678_9ABC_DEF0;
    muldiv_rs2    = 64'd3;
    #1;
    chk("flush_ready_c0", 64'(muldiv_ready), 64'd0);
    for (int c = 1; c <= 20; c++) @(negedge clk);
    muldiv_flush = 1'b1;
    #1;
    chk("flush_ready_c20", 64'(muldiv_ready), 64'd0);
    @(negedge clk);
    muldiv_flush = 1'b0;
    do_op("divu_after_flush", 3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);

    // Reset in the middle of a busy multiply
    muldiv_req    = 1'b1;
    muldiv_funct3 = 3'd0;
    muldiv_rs1    = 64'd7;
    muldiv_rs2    = 64'd9;
    for (int c = 0; c < 10; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy_result", muldiv_result, 64'd0);
    chk("rst_busy_ready", 64'(muldiv_ready), 64'd0);
    do_op("mul_after_rst", 3'd0, 1'b0, 64'd7, 64'd9, 64'd63, 65, 0);

    for (int i = 0; i < 40; i++) begin
      f3  = 3'($urandom_range(0, 7));
      w   = (f3 == 3'd0 || f3[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      case (sel)
        0: b = '0;
        1: begin
             b = ALL1;
             a = w ? {$urandom, 32'h8000_0000} : SMIN;
           end
        2: a = 64'($urandom_range(0, 1000));
        3: b = 64'($urandom_range(1, 50));
        4: b = {32'd0, $urandom};
        default: ;
      endcase
      do_op($sformatf("rand%0d_f%0d_w%0d", i, f3, w), f3, w, a, b,
            model(f3, w, a, b), lat(f3, w, a, b), 0);
    end
    muldiv_req = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
